// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory with request/valid fetch handshake, stall/flush,
// program-load port with same-cycle write-to-read bypass, fault detection and post-reset NOP clear.
module instr_mem_sync #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DEPTH       = 1024,
   parameter logic [DATA_WIDTH-1:0] RESET_INSTR = DATA_WIDTH'(32'h0000_0013),
   localparam int                   IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int                   BO          = $clog2(DATA_WIDTH / 8)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_ready,
   input  logic                  stall,
   input  logic                  flush,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_fault,
   input  logic                  load_en,
   input  logic [IDX_W-1:0]      load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_ready,
   output logic                  init_done
);

   typedef enum logic [0:0] {CLEAR = 1'b0, READY = 1'b1} state_t;

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << BO) - 64'd1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);
   localparam logic [IDX_W:0]        DEPTH_L    = (IDX_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(DEPTH - 1);

   state_t                  state_r;
   state_t                  state_s;
   logic [IDX_W-1:0]        clr_cnt_r;
   logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

   logic                    ready_s;
   logic                    accept_s;
   logic                    fault_s;
   logic                    load_wr_s;
   logic                    bypass_s;
   logic [ADDR_WIDTH-1:0]   word_idx_s;
   logic [IDX_W-1:0]        rd_idx_s;
   logic [DATA_WIDTH-1:0]   rd_data_s;
   logic                    wr_en_s;
   logic [IDX_W-1:0]        wr_idx_s;
   logic [DATA_WIDTH-1:0]   wr_data_s;

   assign ready_s     = (state_r == READY);
   assign load_ready  = ready_s;
   assign init_done   = ready_s;
   assign fetch_ready = ready_s & ~stall;

   assign accept_s   = fetch_req & fetch_ready & ~flush;
   assign word_idx_s = fetch_addr >> BO;
   assign rd_idx_s   = word_idx_s[IDX_W-1:0];
   assign fault_s    = ((fetch_addr & ALIGN_MASK) != {ADDR_WIDTH{1'b0}}) | (word_idx_s >= DEPTH_A);
   assign load_wr_s  = load_en & load_ready & ({1'b0, load_addr} < DEPTH_L);
   // A same-cycle load to the fetched word must win over the stale array contents.
   assign bypass_s   = load_wr_s & (load_addr == rd_idx_s);
   assign rd_data_s  = bypass_s ? load_data : mem_r[rd_idx_s];

   // Next-state logic for the clear sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         CLEAR: begin
            if (clr_cnt_r == LAST_IDX) begin
               state_s = READY;
            end else begin
               state_s = CLEAR;
            end
         end
         READY:   state_s = READY;
         default: state_s = CLEAR;
      endcase
   end

   // Single array write port shared between the clear sequence and the load port.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_idx_s  = {IDX_W{1'b0}};
      wr_data_s = RESET_INSTR;
      case (state_r)
         CLEAR: begin
            wr_en_s   = 1'b1;
            wr_idx_s  = clr_cnt_r;
            wr_data_s = RESET_INSTR;
         end
         READY: begin
            wr_en_s   = load_wr_s;
            wr_idx_s  = load_addr;
            wr_data_s = load_data;
         end
         default: begin
            wr_en_s   = 1'b0;
         end
      endcase
   end

   // State register and clear counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= CLEAR;
         clr_cnt_r <= {IDX_W{1'b0}};
      end else begin
         state_r <= state_s;
         if (state_r == CLEAR) begin
            clr_cnt_r <= clr_cnt_r + IDX_W'(1);
         end
      end
   end

   // Instruction array storage.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_idx_s] <= wr_data_s;
      end
   end

   // Response register: flush, then stall-hold, then accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_valid <= 1'b0;
         instruction <= RESET_INSTR;
         instr_pc    <= {ADDR_WIDTH{1'b0}};
         instr_fault <= 1'b0;
      end else if (flush) begin
         instr_valid <= 1'b0;
      end else if (stall && instr_valid) begin
         instr_valid <= 1'b1;
      end else if (accept_s) begin
         instr_valid <= 1'b1;
         instruction <= fault_s ? RESET_INSTR : rd_data_s;
         instr_pc    <= fetch_addr;
         instr_fault <= fault_s;
      end else begin
         instr_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed self-checking bench for instr_mem_sync at DEPTH=16.
module tb_instr_mem_sync;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int DEPTH = 16;
   localparam int IW = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          reset;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic          fetch_ready;
   logic          stall;
   logic          flush;
   logic          instr_valid;
   logic [DW-1:0] instruction;
   logic [AW-1:0] instr_pc;
   logic          instr_fault;
   logic          load_en;
   logic [IW-1:0] load_addr;
   logic [DW-1:0] load_data;
   logic          load_ready;
   logic          init_done;

   int checks = 0;
   int failures = 0;

   instr_mem_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .stall(stall), .flush(flush),
      .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
      .instr_fault(instr_fault),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .load_ready(load_ready), .init_done(init_done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_resp(input string tag, input logic [31:0] data, input logic [31:0] pc,
                             input logic fault);
      check_val({tag, "_valid"}, 64'(instr_valid), 64'd1);
      check_val({tag, "_data"}, 64'(instruction), 64'(data));
      check_val({tag, "_pc"}, 64'(instr_pc), 64'(pc));
      check_val({tag, "_fault"}, 64'(instr_fault), 64'(fault));
   endtask

   task automatic fetch_one(input logic [31:0] addr);
      fetch_req  = 1'b1;
      fetch_addr = addr;
      step();
      fetch_req  = 1'b0;
   endtask

   task automatic load_one(input logic [3:0] idx, input logic [31:0] data);
      load_en   = 1'b1;
      load_addr = idx;
      load_data = data;
      step();
      load_en   = 1'b0;
   endtask

   task automatic run_init();
      for (int i = 1; i <= DEPTH; i++) begin
         step();
         if (i < DEPTH) begin
            check_val("init_pending", 64'(init_done), 64'd0);
            check_val("no_resp_in_clear", 64'(instr_valid), 64'd0);
         end else begin
            check_val("init_done", 64'(init_done), 64'd1);
            check_val("load_ready", 64'(load_ready), 64'd1);
         end
      end
   endtask

   initial begin
      reset = 1'b0; fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0; flush = 1'b0;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      repeat (3) step();
      check_val("rst_valid", 64'(instr_valid), 64'd0);
      check_val("rst_instr", 64'(instruction), 64'(NOP));
      check_val("rst_pc", 64'(instr_pc), 64'd0);
      check_val("rst_fault", 64'(instr_fault), 64'd0);
      check_val("rst_fetch_ready", 64'(fetch_ready), 64'd0);
      check_val("rst_load_ready", 64'(load_ready), 64'd0);
      check_val("rst_init_done", 64'(init_done), 64'd0);

      // Requests and loads issued during CLEAR must be ignored.
      reset = 1'b1;
      fetch_req = 1'b1; fetch_addr = 32'h0;
      load_en = 1'b1; load_addr = 4'd3; load_data = 32'hFFFF_FFFF;
      run_init();
      fetch_req = 1'b0; load_en = 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
         fetch_req  = 1'b1;
         fetch_addr = 32'(i * 4);
         step();
         check_resp("sweep", NOP, 32'(i * 4), 1'b0);
      end
      fetch_req = 1'b0;

      load_one(4'd5, 32'hDEAD_BEEF);
      fetch_one(32'h14);
      check_resp("load_then_fetch", 32'hDEAD_BEEF, 32'h14, 1'b0);

      load_en = 1'b1; load_addr = 4'd7; load_data = 32'h1234_5678;
      fetch_one(32'h1C);
      load_en = 1'b0;
      check_resp("bypass", 32'h1234_5678, 32'h1C, 1'b0);
      fetch_one(32'h1C);
      check_resp("bypass_stored", 32'h1234_5678, 32'h1C, 1'b0);

      fetch_one(32'h2);
      check_resp("misaligned", NOP, 32'h2, 1'b1);
      fetch_one(32'h40);
      check_resp("out_of_range", NOP, 32'h40, 1'b1);
      step();
      check_val("idle_after_fetch", 64'(instr_valid), 64'd0);

      load_one(4'd0, 32'hAAAA_0000);
      load_one(4'd1, 32'h1111_1111);
      load_one(4'd2, 32'h2222_2222);

      fetch_req = 1'b1; fetch_addr = 32'h0;
      step();
      check_resp("b2b_0", 32'hAAAA_0000, 32'h0, 1'b0);
      fetch_addr = 32'h4;
      step();
      check_resp("b2b_1", 32'h1111_1111, 32'h4, 1'b0);
      fetch_addr = 32'h8; stall = 1'b1;
      #1;
      check_val("stall_fetch_ready", 64'(fetch_ready), 64'd0);
      step();
      check_resp("stall_hold_1", 32'h1111_1111, 32'h4, 1'b0);
      step();
      check_resp("stall_hold_2", 32'h1111_1111, 32'h4, 1'b0);
      stall = 1'b0;
      #1;
      check_val("unstall_fetch_ready", 64'(fetch_ready), 64'd1);
      step();
      check_resp("b2b_2", 32'h2222_2222, 32'h8, 1'b0);

      fetch_addr = 32'h14; stall = 1'b1; flush = 1'b1;
      step();
      check_val("flush_valid", 64'(instr_valid), 64'd0);
      check_val("flush_hold_instr", 64'(instruction), 64'h2222_2222);
      fetch_req = 1'b0; stall = 1'b0; flush = 1'b0;
      step();
      check_val("flush_no_answer", 64'(instr_valid), 64'd0);

      fetch_one(32'h14);
      check_resp("pre_reset", 32'hDEAD_BEEF, 32'h14, 1'b0);
      reset = 1'b0;
      #1;
      check_val("mid_rst_valid", 64'(instr_valid), 64'd0);
      check_val("mid_rst_instr", 64'(instruction), 64'(NOP));
      check_val("mid_rst_pc", 64'(instr_pc), 64'd0);
      check_val("mid_rst_init", 64'(init_done), 64'd0);
      check_val("mid_rst_fetch_ready", 64'(fetch_ready), 64'd0);
      step();
      step();
      reset = 1'b1;
      run_init();
      fetch_one(32'h14);
      check_resp("after_reinit", NOP, 32'h14, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_mem_sync.md
# instr_mem_sync

Parametrised, synchronous-read instruction memory for the RISC-V fetch stage. It replaces the zero-latency combinational instruction ROM with a one-cycle registered read behind a request/valid handshake. It adds stall and flush control, a program-load write port with same-cycle write-to-read bypass, and alignment/range fault detection. A post-reset clear sequencer fills every word with a NOP before fetches are accepted.

## Interface
- DATA_WIDTH, 32, instruction word width in bits; multiple of 8
- ADDR_WIDTH, 32, byte-address width of the fetch port
- DEPTH, 1024, number of instruction words; need not be a power of two
- RESET_INSTR, 32'h00000013, word written by the clear sequence and returned on reset or fault
- Derived: IDX_W = clog2(DEPTH); BO = clog2(DATA_WIDTH/8)

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_WIDTH  byte address of the requested instruction
- fetch_ready  out  1  request accepted this cycle if fetch_req=1
- stall  in  1  downstream stall; holds the current response
- flush  in  1  discard the response and the same-cycle request
- instr_valid  out  1  response valid
- instruction  out  DATA_WIDTH  fetched word
- instr_pc  out  ADDR_WIDTH  fetch_addr of the returned word
- instr_fault  out  1  request was misaligned or out of range
- load_en  in  1  program-load write strobe
- load_addr  in  IDX_W  word index to write
- load_data  in  DATA_WIDTH  word to write
- load_ready  out  1  load port accepting writes
- init_done  out  1  clear sequence complete

## Operation
- FSM has two states: CLEAR and READY. Reset forces CLEAR with clear counter 0.
- CLEAR: writes RESET_INSTR to word[counter] each cycle and increments the counter. At counter = DEPTH-1 the FSM moves to READY after that write. While in CLEAR, fetch_ready, load_ready and init_done are 0, and fetch_req and load_en are ignored.
- READY is terminal until reset. In READY: load_ready=1, init_done=1, and fetch_ready = !stall.
- Accept condition: fetch_req & fetch_ready & !flush.
- Index = fetch_addr >> BO.
- Fault condition: fetch_addr[BO-1:0] != 0, or index >= DEPTH. A faulting request is still accepted and produces a response with instruction=RESET_INSTR and instr_fault=1. No array read occurs.
- Load write condition: load_en & load_ready & (load_addr < DEPTH). An out-of-range load_addr is dropped silently.
- Bypass: if a load writes the same index that an accepted non-faulting fetch reads in the same cycle, the response carries load_data. It never carries the old word.
- Output register update priority, highest first:
  1. flush: instr_valid ← 0; other outputs hold.
  2. stall with instr_valid=1: all response outputs hold.
  3. accepted request: instr_valid ← 1; instruction, instr_pc and instr_fault are loaded.
  4. otherwise: instr_valid ← 0; other outputs hold.
- Loads proceed regardless of stall and flush.

## Timing
- Reset values, applied asynchronously on reset=0: instr_valid 0, instruction RESET_INSTR, instr_pc 0, instr_fault 0, fetch_ready 0, load_ready 0, init_done 0.
- Clear duration: the first rising edge with reset=1 writes word 0. init_done rises after DEPTH edges. The first fetch can be accepted in the cycle where init_done=1.
- Read latency is 1 cycle. A request accepted at edge N is presented from edge N+1.
- Back-to-back accepted requests give one response per cycle, with no bubbles.
- A response held by stall stays valid and unchanged for every stalled cycle. It is replaced on the first edge after stall=0 (new accept) or dropped (no accept).
- A write at edge N is visible to a fetch accepted at edge N through the bypass, and to all later fetches.
- Reset asserted mid-operation aborts any response at once. It restarts CLEAR from word 0, so loaded program contents are lost.

## Test plan
- Reset, DEPTH=16: hold reset=0 for 3 cycles, then release -> init_done=0 for 15 edges and 1 at the 16th. Fetch 0x0 through 0x3C -> every word is 0x00000013, instr_fault=0.
- Load word 5=0xDEADBEEF, then fetch 0x14 the next cycle -> instruction=0xDEADBEEF and instr_pc=0x14 one cycle after accept.
- Same-cycle load of index 7 with 0x12345678 and fetch of 0x1C -> response 0x12345678.
- Fetch 0x2 -> instr_fault=1, instruction=0x00000013. Fetch 0x40 (DEPTH=16) -> instr_fault=1.
- Back-to-back fetches 0x0, 0x4, 0x8 with stall=1 during the second response for 2 cycles -> the second response holds for 3 cycles, fetch_ready=0 while stalled, then the third response follows.
- Assert flush together with stall and fetch_req -> instr_valid=0 next cycle and the request is not answered. Reset=0 mid-stream -> outputs at reset values immediately, and the previously loaded word 5 reads 0x00000013 after re-init.
